// File: rtl/stack_pointer_ctrl_pkg.sv
// Shared definitions for the stack pointer sequencer: command encodings, FSM states
// and stack memory control codes.
package stack_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [3:0] WR_CODE = 4'h1;
    localparam logic [3:0] RD_NONE = 4'h0;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_ADJ  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_e;

endpackage

// File: rtl/stack_pointer_ctrl_if.sv
// Command/response bus between the execute stage (master) and the stack pointer
// sequencer (slave).
interface stack_pointer_ctrl_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/stack_pointer_ctrl_bounds_chk.sv
// Combinational ESP update and bounds check, shared by every stack-moving command.
// Bounds violations are only reported when STACK_BOUNDS_CHECK_EN is defined.
module stack_bounds_chk
    import stack_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] STACK_TOP = ADDR_W'(32'h0000_0100)
) (
    input  logic [ADDR_W-1:0] i_esp,
    input  op_e               i_op,
    input  logic [31:0]       i_delta,
    output logic [ADDR_W-1:0] o_next_esp,
    output logic              o_err
);

`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // One extra bit so a negative ADJUST result is distinguishable from a large ESP.
    localparam int XW = ADDR_W + 1;
    localparam logic signed [XW-1:0] WORD_X = XW'(WORD_BYTES);
    localparam logic signed [XW-1:0] TOP_X  = {1'b0, STACK_TOP};
    localparam logic signed [XW-1:0] ZERO_X = '0;

    logic [ADDR_W-1:0]    w_deltaW;
    logic signed [XW-1:0] w_espX;
    logic signed [XW-1:0] w_newX;
    logic                 w_violation;

    assign w_deltaW = ADDR_W'($signed(i_delta));
    assign w_espX   = $signed({1'b0, i_esp});
    assign w_newX   = w_espX + XW'($signed(i_delta));

    always_comb begin
        o_next_esp  = i_esp;
        w_violation = 1'b0;
        case (i_op)
            OP_PUSH: begin
                o_next_esp  = i_esp - ADDR_W'(WORD_BYTES);
                w_violation = (w_espX < WORD_X);
            end
            OP_POP: begin
                o_next_esp  = i_esp + ADDR_W'(WORD_BYTES);
                w_violation = (w_espX > (TOP_X - WORD_X));
            end
            OP_PEEK: begin
                w_violation = (w_espX > (TOP_X - WORD_X));
            end
            OP_ADJ: begin
                o_next_esp  = i_esp + w_deltaW;
                w_violation = (w_newX < ZERO_X) || (w_newX > TOP_X);
            end
            default: begin
                o_next_esp  = i_esp;
                w_violation = 1'b0;
            end
        endcase
    end

    assign o_err = CHECK_EN & w_violation;

endmodule

// File: rtl/stack_pointer_ctrl.sv
// Stack pointer sequencer: owns ESP and turns PUSH/POP/PEEK/ADJUST commands into stack
// memory cycles. Define STACK_BOUNDS_CHECK_EN to enable bounds checking and resp_err.
module stack_pointer_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ESP_RESET = ADDR_W'(32'h0000_0040),
    parameter logic [ADDR_W-1:0] STACK_TOP = ADDR_W'(32'h0000_0100),
    parameter logic [3:0]        WR_CODE   = stack_pkg::WR_CODE
) (
    input  logic                clock,
    input  logic                reset,
    stack_pointer_ctrl_if.slave bus,
    output logic [ADDR_W-1:0]   esp,
    output logic [3:0]          read_or_write,
    output logic [31:0]         write_data,
    input  logic [31:0]         stack_esp
);
    import stack_pkg::*;

    state_e            r_state;
    state_e            w_stateNext;
    op_e               r_op;
    logic [31:0]       r_data;
    logic [31:0]       r_writeData;
    logic [31:0]       r_respData;
    logic [ADDR_W-1:0] r_esp;
    logic [ADDR_W-1:0] w_nextEsp;
    logic              r_err;
    logic              w_err;

    stack_bounds_chk #(
        .ADDR_W    (ADDR_W),
        .STACK_TOP (STACK_TOP)
    ) u_bounds (
        .i_esp      (r_esp),
        .i_op       (r_op),
        .i_delta    (r_data),
        .o_next_esp (w_nextEsp),
        .o_err      (w_err)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:  if (bus.cmd_valid) w_stateNext = ST_CHECK;
            ST_CHECK: begin
                if (w_err || r_op == OP_ADJ) w_stateNext = ST_DONE;
                else if (r_op == OP_PUSH)    w_stateNext = ST_WRITE;
                else                         w_stateNext = ST_READ;
            end
            ST_WRITE: w_stateNext = ST_DONE;
            ST_READ:  w_stateNext = ST_DONE;
            ST_DONE:  w_stateNext = ST_IDLE;
            default:  w_stateNext = ST_IDLE;
        endcase
    end

    // Response data is cleared on accept so PUSH/ADJUST/errors report zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op        <= OP_PUSH;
            r_data      <= '0;
            r_esp       <= ESP_RESET;
            r_writeData <= '0;
            r_respData  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op       <= op_e'(bus.cmd_op);
                        r_data     <= bus.cmd_data;
                        r_respData <= '0;
                        r_err      <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    r_err <= w_err;
                    if (!w_err && (r_op == OP_PUSH || r_op == OP_ADJ)) r_esp <= w_nextEsp;
                    if (!w_err && r_op == OP_PUSH) r_writeData <= r_data;
                end
                ST_READ: begin
                    r_respData <= stack_esp;
                    if (r_op == OP_POP) r_esp <= w_nextEsp;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_DONE);
    assign bus.resp_data  = r_respData;
    assign bus.resp_err   = r_err;
    assign esp            = r_esp;
    assign write_data     = r_writeData;

    // Reset gates the write strobe immediately so an interrupted PUSH never lands.
    assign read_or_write = (r_state == ST_WRITE && !reset) ? WR_CODE : RD_NONE;

endmodule

// File: tb/tb_stack_pointer_ctrl.sv
// Directed testbench for stack_pointer_ctrl with a byte-addressed 256-byte stack memory
// model; expectations follow whether STACK_BOUNDS_CHECK_EN is defined.
module tb_stack_pointer_ctrl;

`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] esp;
    logic [3:0]  read_or_write;
    logic [31:0] write_data;
    logic [31:0] stack_esp;
    logic [7:0]  mem [256];

    int compared   = 0;
    int mismatched = 0;

    stack_pointer_ctrl_if bus();

    stack_pointer_ctrl #(
        .ADDR_W    (32),
        .ESP_RESET (32'h0000_0040),
        .STACK_TOP (32'h0000_0100),
        .WR_CODE   (4'h1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .esp           (esp),
        .read_or_write (read_or_write),
        .write_data    (write_data),
        .stack_esp     (stack_esp)
    );

    always #5 clock = ~clock;

    // Little-endian word read at esp; addresses past the memory read as zero.
    always_comb begin
        stack_esp = 32'h0;
        if (esp <= 32'd252)
            stack_esp = {mem[esp[7:0] + 8'd3], mem[esp[7:0] + 8'd2],
                         mem[esp[7:0] + 8'd1], mem[esp[7:0]]};
    end

    always @(posedge clock) begin
        if (read_or_write == 4'h1 && esp <= 32'd252) begin
            mem[esp[7:0]]        <= write_data[7:0];
            mem[esp[7:0] + 8'd1] <= write_data[15:8];
            mem[esp[7:0] + 8'd2] <= write_data[23:16];
            mem[esp[7:0] + 8'd3] <= write_data[31:24];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] data,
                                 input logic [31:0] expData, input logic expErr, input int expLat,
                                 input int expWrites, input logic [31:0] expEsp);
        int          lat;
        int          writes;
        bit          got;
        logic [31:0] rData;
        logic        rErr;
        lat = 0; writes = 0; got = 1'b0; rData = '0; rErr = 1'b0;
        @(negedge clock);
        checkOutput({tag, "/ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clock);
            lat++;
            if (lat == 1) checkOutput({tag, "/busy"}, 32'(bus.cmd_ready), 32'd0);
            if (read_or_write != 4'h0) writes++;
            if (bus.resp_valid) begin
                got   = 1'b1;
                rData = bus.resp_data;
                rErr  = bus.resp_err;
            end
        end
        checkOutput({tag, "/resp"},    32'(got),    32'd1);
        checkOutput({tag, "/data"},    rData,       expData);
        checkOutput({tag, "/err"},     32'(rErr),   32'(expErr));
        checkOutput({tag, "/latency"}, 32'(lat),    32'(expLat));
        checkOutput({tag, "/writes"},  32'(writes), 32'(expWrites));
        checkOutput({tag, "/esp"},     esp,         expEsp);
        @(negedge clock);
        checkOutput({tag, "/pulse"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Preload word at address a with a/4 + 1.
        for (int a = 0; a < 256; a += 4) begin
            logic [31:0] w;
            w = 32'(a / 4 + 1);
            mem[a]     = w[7:0];
            mem[a + 1] = w[15:8];
            mem[a + 2] = w[23:16];
            mem[a + 3] = w[31:24];
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 32'h0;
        reset         = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst/rw",        32'(read_or_write),  32'h0);
        checkOutput("rst/esp",       esp,                 32'h40);
        checkOutput("rst/respValid", 32'(bus.resp_valid), 32'h0);
        checkOutput("rst/respData",  bus.resp_data,       32'h0);
        checkOutput("rst/respErr",   32'(bus.resp_err),   32'h0);
        checkOutput("rst/writeData", write_data,          32'h0);
        reset = 1'b0;

        applyStimulus("peek40",  2'b10, 32'h0,         32'h11,        1'b0, 3, 0, 32'h40);
        applyStimulus("adjM8",   2'b11, 32'hFFFF_FFF8, 32'h0,         1'b0, 2, 0, 32'h38);
        applyStimulus("peek38",  2'b10, 32'h0,         32'h0000_000F, 1'b0, 3, 0, 32'h38);
        applyStimulus("adjP8",   2'b11, 32'h8,         32'h0,         1'b0, 2, 0, 32'h40);
        applyStimulus("push",    2'b00, 32'hDEAD_BEEF, 32'h0,         1'b0, 3, 1, 32'h3C);
        applyStimulus("pop",     2'b01, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0, 32'h40);
        applyStimulus("adjTo4",  2'b11, 32'hFFFF_FFC4, 32'h0,         1'b0, 2, 0, 32'h4);
        applyStimulus("pushAt4", 2'b00, 32'h11,        32'h0,         1'b0, 3, 1, 32'h0);
        applyStimulus("pushAt0", 2'b00, 32'h22,        32'h0,         CHK,
                      CHK ? 2 : 3, CHK ? 0 : 1, CHK ? 32'h0 : 32'hFFFF_FFFC);
        applyStimulus("adjToFC", 2'b11, CHK ? 32'hFC : 32'h100, 32'h0, 1'b0, 2, 0, 32'hFC);
        applyStimulus("popAtFC", 2'b01, 32'h0,         32'h40,        1'b0, 3, 0, 32'h100);
        applyStimulus("popAtTop", 2'b01, 32'h0,        32'h0,         CHK,
                      CHK ? 2 : 3, 0, CHK ? 32'h100 : 32'h104);
        applyStimulus("adjPastTop", 2'b11, 32'h4,      32'h0,         CHK,
                      2, 0, CHK ? 32'h100 : 32'h108);

        // Reset lands during the WRITE cycle of a PUSH.
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 32'hCAFE_F00D;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rstWr/wrCycle", 32'(read_or_write), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("rstWr/rwInReset", 32'(read_or_write), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("rstWr/rwAfter", 32'(read_or_write), 32'h0);
        checkOutput("rstWr/esp",     esp,                32'h40);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("rstWr/noResp", 32'(bus.resp_valid), 32'h0);
            checkOutput("rstWr/noWrite", 32'(read_or_write), 32'h0);
        end
        checkOutput("rstWr/ready", 32'(bus.cmd_ready), 32'h1);

        applyStimulus("adjTo0",    2'b11, 32'hFFFF_FFC0, 32'h0, 1'b0, 2, 0, 32'h0);
        applyStimulus("adjToTop",  2'b11, 32'h100,       32'h0, 1'b0, 2, 0, 32'h100);
        applyStimulus("peekAtTop", 2'b10, 32'h0,         32'h0, CHK, CHK ? 2 : 3, 0, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
